// File: rtl/vector_alu_sequencer.sv
// Vector ALU sequencer: breaks a 4-lane 128-bit vector op into four 32-bit
// beats on a shared external ALU. A scalar request always wins the ALU for
// the cycle it is raised; the vector op simply waits that cycle.
//
// Handshake: VStart is a single-cycle request accepted only in IDLE or DONE
// (ignored in RUN). VBusy is high for every RUN cycle. VDone is a one-cycle
// valid pulse for VResult. SGrant mirrors SReq combinationally, even in reset.
module vector_alu_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         VStart,
  input  logic [2:0]   VALUControl,
  input  logic [127:0] VSrcA,
  input  logic [127:0] VSrcB,
  input  logic         SReq,
  input  logic [2:0]   SALUControl,
  input  logic [31:0]  SSrcA,
  input  logic [31:0]  SSrcB,
  input  logic [31:0]  ALUResult,
  output logic [31:0]  ALUSrcA,
  output logic [31:0]  ALUSrcB,
  output logic [2:0]   ALUControl,
  output logic         ALUOwner,
  output logic         SGrant,
  output logic         VBusy,
  output logic         VDone,
  output logic [127:0] VResult
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic [127:0] a_q, a_d;
  logic [127:0] b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic [127:0] vres_q, vres_d;

  logic [31:0]  lane_a;
  logic [31:0]  lane_b;
  logic         beat_go;

  // Select the latched operand lanes addressed by the current beat.
  always_comb begin
    lane_a = a_q[31:0];
    lane_b = b_q[31:0];
    case (beat_q)
      2'd0: begin lane_a = a_q[31:0];   lane_b = b_q[31:0];   end
      2'd1: begin lane_a = a_q[63:32];  lane_b = b_q[63:32];  end
      2'd2: begin lane_a = a_q[95:64];  lane_b = b_q[95:64];  end
      default: begin lane_a = a_q[127:96]; lane_b = b_q[127:96]; end
    endcase
  end

  // A beat is issued only when the vector op owns the ALU this cycle.
  assign beat_go = (state_q == S_RUN) && !SReq;

  // Next-state, operand latch, beat counter and result lane write-back.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    vres_d  = vres_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (VStart) begin
          a_d     = VSrcA;
          b_d     = VSrcB;
          op_d    = VALUControl;
          beat_d  = 2'd0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (beat_go) begin
          case (beat_q)
            2'd0:    vres_d[31:0]   = ALUResult;
            2'd1:    vres_d[63:32]  = ALUResult;
            2'd2:    vres_d[95:64]  = ALUResult;
            default: vres_d[127:96] = ALUResult;
          endcase
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shared-ALU operand mux: scalar pass-through unless a vector beat issues.
  always_comb begin
    ALUSrcA    = SSrcA;
    ALUSrcB    = SSrcB;
    ALUControl = SALUControl;
    ALUOwner   = 1'b0;
    if (beat_go) begin
      ALUSrcA    = lane_a;
      ALUSrcB    = lane_b;
      ALUControl = op_q;
      ALUOwner   = 1'b1;
    end
  end

  assign SGrant  = SReq;
  assign VBusy   = (state_q == S_RUN);
  assign VDone   = (state_q == S_DONE);
  assign VResult = vres_q;

  // State registers with synchronous reset; reset beats a same-cycle VStart.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      vres_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      vres_q  <= vres_d;
    end
  end

endmodule
